// File: rtl/btn_mode_ctrl.sv
// Front-panel key controller: 2-flop sync, per-key debounce, press pulses and a
// one-hot mode ring stepped by key MODE_BTN. Optional auto-repeat: LONGPRESS_REPEAT_EN.
module btn_mode_ctrl #(
  parameter int unsigned NUM_BTN       = 4,
  parameter int unsigned NUM_MODE      = 4,
  parameter int unsigned MODE_BTN      = 3,
  parameter int unsigned DEB_CYCLES    = 1000000,
  parameter int unsigned HOLD_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000
) (
  input  logic                        clk50mhz,
  input  logic                        rst_n,
  input  logic [NUM_BTN-1:0]          btn_in,
  input  logic                        lock,
  output logic [NUM_BTN-1:0]          btn_level,
  output logic [NUM_BTN-1:0]          btn_press,
  output logic [NUM_MODE-1:0]         mode,
  output logic [$clog2(NUM_MODE)-1:0] mode_idx,
  output logic                        mode_chg
);

  localparam int unsigned IDX_W = $clog2(NUM_MODE);
  localparam int unsigned CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  localparam logic [NUM_MODE-1:0] MODE_RST = NUM_MODE'(1);
  localparam logic [IDX_W-1:0]    IDX_RST  = '0;
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_MODE - 1);

  logic [NUM_BTN-1:0]  sync1_q, sync2_q;
  logic [NUM_BTN-1:0]  level_q, level_d;
  logic [NUM_BTN-1:0]  press_q, press_d;
  logic [NUM_BTN-1:0]  rise;
  logic [CNT_W-1:0]    cnt_q [NUM_BTN];
  logic [CNT_W-1:0]    cnt_d [NUM_BTN];
  logic [NUM_MODE-1:0] mode_q, mode_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                chg_q, chg_d;
  logic                step;

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Counter runs only while the synced input disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rise = level_d & ~level_q;

`ifdef LONGPRESS_REPEAT_EN
  localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HOLD_W   = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  logic [HOLD_W-1:0]  hold_q [NUM_BTN];
  logic [HOLD_W-1:0]  hold_d [NUM_BTN];
  logic [NUM_BTN-1:0] rep_q, rep_d, rep_fire;

  // Hold timing starts the cycle after the initial press and stops on the
  // releasing edge, so no pulse can coincide with a falling level.
  always_comb begin
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      hold_d[i]   = '0;
      rep_d[i]    = 1'b0;
      rep_fire[i] = 1'b0;
      if (i != MODE_BTN && level_q[i] && level_d[i]) begin
        rep_d[i] = rep_q[i];
        if (rep_q[i] ? (hold_q[i] == REP_LAST) : (hold_q[i] == HOLD_LAST)) begin
          rep_fire[i] = 1'b1;
          rep_d[i]    = 1'b1;
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      rep_q <= rep_d;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign press_d = rise | rep_fire;
`else
  // Auto-repeat timing has no effect in this build.
  if (HOLD_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_repeat_unused
  end

  assign press_d = rise;
`endif

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      press_q <= '0;
    end else begin
      press_q <= press_d;
    end
  end

  // Mode ring: one state per mode; a press seen while locked is simply dropped.
  assign step = press_q[MODE_BTN] & ~lock;

  always_comb begin
    mode_d = mode_q;
    idx_d  = idx_q;
    chg_d  = 1'b0;
    if (step) begin
      mode_d = {mode_q[NUM_MODE-2:0], mode_q[NUM_MODE-1]};
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      chg_d  = 1'b1;
    end
  end

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_RST;
      idx_q  <= IDX_RST;
      chg_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      idx_q  <= idx_d;
      chg_q  <= chg_d;
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;
  assign mode      = mode_q;
  assign mode_idx  = idx_q;
  assign mode_chg  = chg_q;

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// Directed bench for btn_mode_ctrl with short debounce/hold timings;
// repeat-pulse expectations follow LONGPRESS_REPEAT_EN.
module tb_btn_mode_ctrl;

  logic       clk50mhz = 1'b0;
  logic       rst_n;
  logic [3:0] btn_in;
  logic       lock;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] mode;
  logic [1:0] mode_idx;
  logic       mode_chg;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  btn_mode_ctrl #(
    .NUM_BTN      (4),
    .NUM_MODE     (4),
    .MODE_BTN     (3),
    .DEB_CYCLES   (4),
    .HOLD_CYCLES  (20),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk50mhz (clk50mhz),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .lock     (lock),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .mode     (mode),
    .mode_idx (mode_idx),
    .mode_chg (mode_chg)
  );

  always #5 clk50mhz = ~clk50mhz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50mhz);
    #1;
  endtask

  task automatic wait_press(input int k, input string tag);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      if (btn_press[k]) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic release_all(input string tag);
    bit any_press;
    any_press = 1'b0;
    btn_in = '0;
    repeat (8) begin
      tick();
      if (btn_press != 4'b0000) any_press = 1'b1;
    end
    check({tag, "_rel_nopulse"}, 32'(any_press), 32'd0);
    check({tag, "_rel_level"}, 32'(btn_level), 32'd0);
  endtask

  task automatic mode_press(input string tag, input logic [3:0] exp_mode,
                            input logic [1:0] exp_idx, input logic exp_chg);
    btn_in[3] = 1'b1;
    wait_press(3, {tag, "_press"});
    check({tag, "_chg_at_press"}, 32'(mode_chg), 32'd0);
    tick();
    check({tag, "_mode"}, 32'(mode), 32'(exp_mode));
    check({tag, "_idx"}, 32'(mode_idx), 32'(exp_idx));
    check({tag, "_chg"}, 32'(mode_chg), 32'(exp_chg));
    tick();
    check({tag, "_chg_clr"}, 32'(mode_chg), 32'd0);
    release_all(tag);
  endtask

  function automatic bit rep_expected(input int c);
`ifdef LONGPRESS_REPEAT_EN
    return (c == 20 || c == 28 || c == 36 || c == 44 || c == 52);
`else
    return (c < 0);
`endif
  endfunction

  initial begin
    int first_at;
    int pulses;

    rst_n  = 1'b0;
    btn_in = '0;
    lock   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_mode", 32'(mode), 32'h1);
    check("rst_idx", 32'(mode_idx), 32'd0);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_press", 32'(btn_press), 32'd0);
    check("rst_chg", 32'(mode_chg), 32'd0);

    // Bounce 1,0,1 at 2-cycle spacing, then hold
    pulses = 0;
    btn_in[0] = 1'b1;
    repeat (2) begin tick(); if (btn_press[0]) pulses++; end
    btn_in[0] = 1'b0;
    repeat (2) begin tick(); if (btn_press[0]) pulses++; end
    btn_in[0] = 1'b1;
    first_at = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (btn_press[0]) begin
        pulses++;
        if (first_at < 0) first_at = c;
      end
    end
    check("bounce_latency", 32'(first_at), 32'd6);
    check("bounce_pulses", 32'(pulses), 32'd1);
    check("bounce_level", 32'(btn_level[0]), 32'd1);
    check("bounce_mode", 32'(mode), 32'h1);
    release_all("bounce");

    mode_press("wrap1", 4'b0010, 2'd1, 1'b1);
    mode_press("wrap2", 4'b0100, 2'd2, 1'b1);
    mode_press("wrap3", 4'b1000, 2'd3, 1'b1);
    mode_press("wrap4", 4'b0001, 2'd0, 1'b1);

    lock = 1'b1;
    mode_press("lock", 4'b0001, 2'd0, 1'b0);
    lock = 1'b0;
    mode_press("unlock", 4'b0010, 2'd1, 1'b1);

    btn_in[3] = 1'b1;
    btn_in[1] = 1'b1;
    wait_press(3, "sim_press3");
    check("sim_press1", 32'(btn_press[1]), 32'd1);
    tick();
    check("sim_mode", 32'(mode), 32'b0100);
    check("sim_chg", 32'(mode_chg), 32'd1);
    tick();
    check("sim_mode_once", 32'(mode), 32'b0100);
    check("sim_chg_clr", 32'(mode_chg), 32'd0);
    release_all("sim");

    // Hold key 1; release after cycle +50, level falls at +56
    btn_in[1] = 1'b1;
    wait_press(1, "rep_press");
    for (int c = 1; c <= 60; c++) begin
      tick();
      check($sformatf("rep_c%0d", c), 32'(btn_press[1]), 32'(rep_expected(c)));
      if (c == 50) btn_in[1] = 1'b0;
    end
    check("rep_level_off", 32'(btn_level[1]), 32'd0);
    check("rep_mode", 32'(mode), 32'b0100);

    // Asynchronous reset in the middle of a hold
    btn_in[1] = 1'b1;
    wait_press(1, "arst_press");
    for (int c = 1; c <= 25; c++) begin
      tick();
      check($sformatf("arst_c%0d", c), 32'(btn_press[1]), 32'(rep_expected(c) && c <= 20));
    end
    check("arst_mode_pre", 32'(mode), 32'b0100);
    #2;
    rst_n  = 1'b0;
    btn_in = '0;
    #1;
    check("arst_mode", 32'(mode), 32'h1);
    check("arst_idx", 32'(mode_idx), 32'd0);
    check("arst_level", 32'(btn_level), 32'd0);
    check("arst_press", 32'(btn_press), 32'd0);
    check("arst_chg", 32'(mode_chg), 32'd0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    repeat (30) begin
      tick();
      if (btn_press != 4'b0000) pulses++;
    end
    check("arst_nopulse", 32'(pulses), 32'd0);
    check("arst_mode_post", 32'(mode), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
